// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grants, owner-held tenures and an
// optional hold-limit timer that forces release after HOLD_MAX cycles.
module round_robin_arbiter #(
    parameter int WIDTH          = 8,
    parameter int HOLD_MAX       = 16,
    parameter int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    output logic [WIDTH-1:0]     gnt,
    output logic [WIDTH_LOG-1:0] gnt_idx,
    output logic                 gnt_vld,
    output logic                 tmo
);

    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     gnt_q, gnt_d;
    logic [WIDTH_LOG-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]     msk_q, msk_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tmo_q, tmo_d;

    logic                 rel_norm, rel_frc, load;
    logic [WIDTH-1:0]     arb_in, arb_msk, arb_sel, arb_out;
    logic [WIDTH_LOG-1:0] arb_idx;

    assign rel_norm = (state_q == BUSY) && ((req & gnt_q) == '0);
    assign rel_frc  = (state_q == BUSY) && (HOLD_MAX != 0) && (cnt_q == CNT_LAST) && !rel_norm;

    // On a normal release the departing owner is excluded; gnt_q is zero in IDLE.
    assign arb_in  = rel_frc ? req : (req & ~gnt_q);
    assign arb_msk = arb_in & msk_q;
    assign arb_sel = (arb_msk != '0) ? arb_msk : arb_in;

    generate
        if (IMPLEMENTATION == 0) begin : g_adder
            assign arb_out = arb_sel & (~arb_sel + WIDTH'(1));
        end else begin : g_loop
            always_comb begin
                arb_out = '0;
                for (int i = WIDTH - 1; i >= 0; i--)
                    if (arb_sel[i]) arb_out = WIDTH'(1) << i;
            end
        end
    endgenerate

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (arb_out[i]) arb_idx = WIDTH_LOG'(i);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        msk_d   = msk_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: load = (req != '0);
            BUSY: begin
                if (rel_norm || rel_frc) begin
                    load  = 1'b1;
                    tmo_d = rel_frc;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            gnt_d = arb_out;
            idx_d = arb_idx;
            cnt_d = '0;
            if (arb_out != '0) begin
                state_d = BUSY;
                // Everything strictly above the new grantee gets priority next time.
                msk_d   = ~(arb_out | (arb_out - WIDTH'(1)));
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            msk_q   <= '1;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            msk_q   <= msk_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;
    assign tmo     = tmo_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench: each configuration is built with both priority-encoder forms,
// and every check is applied to both instances against the same expected value.
module tb_round_robin_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] req_a, req_b;
    logic [7:0] req_c;

    logic [1:0][3:0] a_gnt, b_gnt;
    logic [1:0][1:0] a_idx, b_idx;
    logic [1:0]      a_vld, a_tmo, b_vld, b_tmo;
    logic [1:0][7:0] c_gnt;
    logic [1:0][2:0] c_idx;
    logic [1:0]      c_vld, c_tmo;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_impl
            round_robin_arbiter #(.WIDTH(4), .HOLD_MAX(0), .IMPLEMENTATION(g)) u_a (
                .clk(clk), .rst_n(rst_n), .req(req_a),
                .gnt(a_gnt[g]), .gnt_idx(a_idx[g]), .gnt_vld(a_vld[g]), .tmo(a_tmo[g]));
            round_robin_arbiter #(.WIDTH(4), .HOLD_MAX(4), .IMPLEMENTATION(g)) u_b (
                .clk(clk), .rst_n(rst_n), .req(req_b),
                .gnt(b_gnt[g]), .gnt_idx(b_idx[g]), .gnt_vld(b_vld[g]), .tmo(b_tmo[g]));
            round_robin_arbiter #(.WIDTH(8), .HOLD_MAX(16), .IMPLEMENTATION(g)) u_c (
                .clk(clk), .rst_n(rst_n), .req(req_c),
                .gnt(c_gnt[g]), .gnt_idx(c_idx[g]), .gnt_vld(c_vld[g]), .tmo(c_tmo[g]));
        end
    endgenerate

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] i);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.gnt[%0d]", tag, m), a_gnt[m], g);
            chk($sformatf("%s.idx[%0d]", tag, m), a_idx[m], i);
            chk($sformatf("%s.vld[%0d]", tag, m), a_vld[m], |g);
        end
    endtask

    task automatic chk_b(input string tag, input logic [3:0] g, input logic [1:0] i, input logic t);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.gnt[%0d]", tag, m), b_gnt[m], g);
            chk($sformatf("%s.idx[%0d]", tag, m), b_idx[m], i);
            chk($sformatf("%s.tmo[%0d]", tag, m), b_tmo[m], t);
            chk($sformatf("%s.vld[%0d]", tag, m), b_vld[m], |g);
        end
    endtask

    task automatic chk_c(input string tag, input logic [7:0] g, input logic [2:0] i, input logic t);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.gnt[%0d]", tag, m), c_gnt[m], g);
            chk($sformatf("%s.idx[%0d]", tag, m), c_idx[m], i);
            chk($sformatf("%s.tmo[%0d]", tag, m), c_tmo[m], t);
            chk($sformatf("%s.vld[%0d]", tag, m), c_vld[m], |g);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = 8'hFF;

        // Reset with all requests high, then first grant goes to index 0
        step();
        step();
        chk_c("rst", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_c("rst_first", 8'h01, 3'd0, 1'b0);

        // HOLD_MAX=0: owner handoff and mask wrap
        do_reset();
        req_a = 4'b1010;
        step();
        chk_a("a_first", 4'b0010, 2'd1);
        req_a = 4'b1000;
        step();
        chk_a("a_hand", 4'b1000, 2'd3);
        req_a = 4'b1010;
        step();
        chk_a("a_hold", 4'b1000, 2'd3);
        req_a = 4'b0010;
        step();
        chk_a("a_wrap", 4'b0010, 2'd1);

        // HOLD_MAX=0: owner drops with nobody waiting -> idle, then restart
        do_reset();
        req_a = 4'b0100;
        step();
        chk_a("a_own2", 4'b0100, 2'd2);
        req_a = 4'b0000;
        step();
        chk_a("a_idle", 4'b0000, 2'd0);
        req_a = 4'b0011;
        step();
        chk_a("a_regnt", 4'b0001, 2'd0);
        req_a = 4'b0010;
        step();
        chk_a("a_next", 4'b0010, 2'd1);

        // HOLD_MAX=4: all requesting, forced rotation every 4 cycles
        do_reset();
        req_b = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            chk_b($sformatf("rot%0d", k), 4'(1 << ((k / 4) % 4)), 2'((k / 4) % 4),
                  (k % 4 == 0) && (k > 0));
        end

        // HOLD_MAX=4: single requester is re-granted with a tmo pulse each tenure
        do_reset();
        req_b = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            step();
            chk_b($sformatf("solo%0d", k), 4'b0100, 2'd2, (k % 4 == 0) && (k > 0));
        end

        // Owner drops exactly at the hold limit: normal release, no tmo
        do_reset();
        req_b = 4'b0011;
        step();
        chk_b("both_k0", 4'b0001, 2'd0, 1'b0);
        step();
        step();
        step();
        chk_b("both_k3", 4'b0001, 2'd0, 1'b0);
        req_b = 4'b0010;
        step();
        chk_b("both_rel", 4'b0010, 2'd1, 1'b0);

        // Mid-tenure reset clears outputs asynchronously
        do_reset();
        req_a = 4'b1000;
        step();
        chk_a("mid_own", 4'b1000, 2'd3);
        #2 rst_n = 1'b0;
        #1 chk_a("mid_rst", 4'b0000, 2'd0);
        rst_n = 1'b1;
        step();
        chk_a("mid_rel", 4'b1000, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Round-robin arbiter that shares one resource among WIDTH requesters, built around the rightmost-priority-to-one-hot conversion (adder or loop form, selectable). A rotating mask makes the most recently served requester the lowest priority. Grants are registered and held for a tenure, which the owner ends or a hold-limit timer forces to end. The block sits between requester ports and a shared datapath (bus, memory port, functional unit).

## Interface
Parameters:
- WIDTH, 8: number of requesters (≥2).
- WIDTH_LOG, $clog2(WIDTH): localparam, width of the grant index.
- HOLD_MAX, 16: maximum tenure in cycles. 0 disables forced release.
- IMPLEMENTATION, 0: priority-to-one-hot form. 0 = adder (`x & -x`), 1 = loop.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  WIDTH  request vector; bit i high = requester i wants or keeps the resource.
- gnt  out  WIDTH  registered one-hot grant; all zeros when idle.
- gnt_idx  out  WIDTH_LOG  binary index of the gnt bit; 0 when idle.
- gnt_vld  out  1  high while any grant is held (= |gnt).
- tmo  out  1  one-cycle pulse, high in the first cycle after a forced release.

## Operation
- Registered state:
  - gnt
  - gnt_idx
  - state: IDLE or BUSY
  - msk (WIDTH): bits strictly above the last grantee
  - cnt: tenure counter, $clog2(HOLD_MAX+1) bits, minimum 1
  - tmo
- Arbitration function arb(r):
  - m = r & msk.
  - If m ≠ 0, result = rightmost-one(m); otherwise result = rightmost-one(r).
  - rightmost-one(0) = 0.
- IDLE:
  - req = 0: stay IDLE.
  - req ≠ 0: at the next edge, gnt ← arb(req), state ← BUSY, cnt ← 0.
- BUSY, owner index k:
  - Normal release: req[k] = 0.
  - Forced release: HOLD_MAX ≠ 0 and cnt = HOLD_MAX−1. tmo ← 1 at that edge.
  - If both release conditions hold, treat it as a normal release (tmo stays 0).
  - On either release, at the same edge: n = arb(req & ~onehot(k)) when releasing normally, n = arb(req) when forced.
    - n ≠ 0: gnt ← n, cnt ← 0, stay BUSY. No idle gap.
    - n = 0: gnt ← 0, state ← IDLE.
  - No release: gnt held, cnt ← cnt+1.
- Mask update: every edge that loads a new grant with index j sets msk ← bits (WIDTH−1 .. j+1).
  - j = WIDTH−1 gives msk = 0, so the next arbitration wraps to the rightmost request.
- Requests from non-owners never disturb a held grant.
  - A request raised and dropped while another requester is the owner is never seen.
- Forced release with only the owner requesting: the owner is re-granted at the same edge. gnt stays constant, cnt ← 0, tmo pulses.
- gnt is always one-hot or zero. gnt_idx is always consistent with gnt.

## Timing
- Reset (asynchronous assert, synchronous release): gnt = 0, gnt_idx = 0, gnt_vld = 0, tmo = 0, state = IDLE, cnt = 0, msk = all ones (index 0 has top priority).
- Request-to-grant latency: 1 edge from IDLE.
- Owner drop to next grant: 1 edge, with no dead cycle.
- gnt_vld is combinational from gnt, so it has the same timing as gnt.
- Maximum tenure: exactly HOLD_MAX cycles of gnt high.
- Worst-case wait for a requester holding req high: (WIDTH−1)·HOLD_MAX + 1 cycles.
- Reset asserted mid-tenure: all outputs clear immediately, with no glitch to another grant. Arbitration restarts from msk = all ones.
- tmo is high for exactly one cycle per forced release, aligned with the first cycle of the following tenure (or the idle cycle).

## Test plan
- Reset: hold rst_n = 0 with req = 8'hFF, then release. All outputs are 0 during reset; gnt = 8'h01, gnt_idx = 0 one edge after release.
- WIDTH=4, HOLD_MAX=0, from reset: req = 4'b1010 gives gnt = 0010, idx 1. Clearing req[1] gives gnt = 1000, idx 3 at the next edge. Clearing req[3] then gives gnt = 0010, since the mask wrapped.
- WIDTH=4, HOLD_MAX=4, req = 4'b1111 held constant:
  - gnt sequence 0001, 0010, 0100, 1000, 0001, with each grant lasting exactly 4 cycles.
  - tmo pulses once at each transition.
  - gnt_vld stays high throughout.
- WIDTH=4, HOLD_MAX=4, req = 4'b0100 only: gnt = 0100 continuously. tmo pulses every 4 cycles, and cnt restarts each time.
- WIDTH=4, HOLD_MAX=0: owner idx 2 drops req with req = 0 elsewhere, giving gnt = 0 and gnt_vld = 0 at the next edge. A new req = 4'b0011 then gives gnt = 0001.
- Mid-tenure reset: with idx 3 granted, pulse rst_n low between edges. gnt clears asynchronously. After release with req = 4'b1000, gnt = 1000 at the first edge.
- Run all scenarios with IMPLEMENTATION = 0 and 1. Grant traces must be identical.
